// File: rtl/ram_unshifter.sv
// Scans a 1-bit RAM bank into an IO_WIDTH word. out_valid rises IO_WIDTH cycles after SCAN entry.
// The word is held in HOLD until out_ready is seen; scanning stalls for as long as the consumer does.
module ram_unshifter #(
  parameter int IO_WIDTH   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  bank_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_bank,
  input  logic                  ram_dout,
  output logic [IO_WIDTH-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            frame_cnt
);

  generate
    if (IO_WIDTH != 2**ADDR_WIDTH) begin : g_bad_params
      $error("ram_unshifter: IO_WIDTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t              state, state_nxt;
  logic [IO_WIDTH-1:0] shreg, word_nxt;
  logic                last_bit, handshake, start;

  always_comb begin
    word_nxt           = shreg;
    word_nxt[ram_addr] = ram_dout;
    last_bit           = (ram_addr == ADDR_WIDTH'(IO_WIDTH - 1));
    handshake          = (state == HOLD) && out_valid && out_ready;
    // A frame starts either from idle or directly out of a completed handshake.
    start              = en && ((state == IDLE) || handshake);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = SCAN;
      SCAN:    if (last_bit) state_nxt = HOLD;
      HOLD:    if (handshake) state_nxt = en ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_bank  <= 1'b0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (start) begin
        ram_bank <= bank_req;
        ram_addr <= '0;
      end
      if (state == SCAN) begin
        shreg <= word_nxt;
        if (last_bit) begin
          out_data  <= word_nxt;
          out_valid <= 1'b1;
          ram_addr  <= '0;
        end else begin
          ram_addr  <= ram_addr + ADDR_WIDTH'(1);
        end
      end
      if (handshake) begin
        out_valid <= 1'b0;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/ram_unshifter.md
RAM_UNSHIFTER -- requirements
Module: ram_unshifter

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 16, output word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, RAM read-address width; IO_WIDTH SHALL equal 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  scan enable, sampled only at frame start.
REQ-006 SHALL have port bank_req  input  1  requested read bank, sampled only at frame start.
REQ-007 SHALL have port ram_addr  output  ADDR_WIDTH  read address into the 1-bit dual-port RAM (DPRA[ADDR_WIDTH-1:0]).
REQ-008 SHALL have port ram_bank  output  1  read-bank bit (DPRA MSB).
REQ-009 SHALL have port ram_dout  input  1  asynchronous-read RAM data (DPO) for {ram_bank, ram_addr}.
REQ-010 SHALL have port out_data  output  IO_WIDTH  assembled word.
REQ-011 SHALL have port out_valid  output  1  out_data holds a complete frame.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port frame_cnt  output  8  count of accepted frames.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, HOLD.
REQ-015 In IDLE, when en=1 the block SHALL latch bank_req into ram_bank, set ram_addr=0 and enter SCAN on the next edge; when en=0 it SHALL stay in IDLE.
REQ-016 In SCAN, each cycle SHALL write ram_dout into shift-register bit index ram_addr, then increment ram_addr.
REQ-017 In SCAN with ram_addr=IO_WIDTH-1, the block SHALL capture the last bit, copy the full word to out_data, assert out_valid, wrap ram_addr to 0 and enter HOLD on the same edge.
REQ-018 Frame latency SHALL be exactly IO_WIDTH cycles from SCAN entry to out_valid=1.
REQ-019 out_data SHALL equal {RAM[bank][IO_WIDTH-1], ..., RAM[bank][0]}; the RAM bit at address k maps to out_data[k].
REQ-020 In HOLD, out_data and out_valid SHALL stay stable until out_valid & out_ready at an edge.
REQ-021 On handshake, the block SHALL increment frame_cnt modulo 256, so that 255 wraps to 0.
REQ-022 On handshake with en=1, the block SHALL deassert out_valid, latch bank_req into ram_bank and enter SCAN with ram_addr=0.
REQ-023 On handshake with en=0, the block SHALL deassert out_valid and enter IDLE.
REQ-024 out_ready high while out_valid=0 SHALL have no effect.
REQ-025 Changes on bank_req or en during SCAN or HOLD SHALL NOT affect the frame in progress; ram_bank SHALL change only at frame start.
REQ-026 ram_addr SHALL hold its value in IDLE and HOLD.
REQ-027 The block SHALL never drive a write; writes to the RAM are owned by a separate writer.

Reset
REQ-028 rst_n=0 SHALL, asynchronously, force state=IDLE, ram_addr=0, ram_bank=0, out_data=0, out_valid=0, frame_cnt=0, and clear the shift register.
REQ-029 A reset asserted mid-SCAN or mid-HOLD SHALL discard the partial or pending frame with no handshake and no frame_cnt increment.
REQ-030 After rst_n deasserts, the first state change SHALL occur on the first rising clk edge at which rst_n=1.

Verification
REQ-031 Bench RAM model bank0=16'h96A5, bank1=16'h5A3C, en=1, bank_req=0, out_ready=1 -> out_valid rises 16 cycles after SCAN entry with out_data=16'h96A5, and frame_cnt=1 after the handshake.
REQ-032 bank_req toggled 0->1 mid-SCAN -> current frame=16'h96A5; next frame=16'h5A3C; ram_bank changes only at the handshake edge.
REQ-033 out_ready=0 for 10 cycles after out_valid -> out_data held at 16'h96A5, ram_addr frozen at 0; handshake on the 11th cycle -> frame_cnt increments by exactly 1.
REQ-034 en dropped during SCAN -> frame completes and handshakes, FSM enters IDLE, ram_addr stays 0, no further out_valid until en=1.
REQ-035 rst_n pulsed low at ram_addr=7 -> all outputs 0 immediately, without waiting for a clock edge; the next frame after release is complete and correct (16'h96A5).
REQ-036 256 back-to-back frames with out_ready=1 -> frame_cnt wraps to 0, and consecutive out_valid pulses are spaced 17 cycles apart (16 SCAN + 1 HOLD).
